// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, BCD field widths and wrap limits for the clock core
package clock_pkg;
    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;
    localparam int HR_W   = 6;
    localparam int MS_W   = 7;
    localparam int HR_MAX = 23;
    localparam int MS_MAX = 59;
endpackage

// File: rtl/bcd2_wrap_ctr.sv
// bcd2_wrap_ctr: two-digit BCD up/down counter wrapping between 0 and MAX
// Ports: clk, rst (async, active-high); inc/dec step the value (both together hold),
// clr zeroes it (highest priority); value = {tens, ones}; carry = inc while value == MAX.
module bcd2_wrap_ctr #(
    parameter int MAX = 59,
    parameter int W   = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);
    localparam logic [W-1:0] MAX_BCD = {(W-4)'(MAX / 10), 4'(MAX % 10)};
    logic [W-5:0] tens;
    logic [3:0]   ones;
    logic [W-1:0] up, dn;
    assign tens  = value[W-1:4];
    assign ones  = value[3:0];
    assign carry = inc && value == MAX_BCD;
    always_comb begin
        up = (value == MAX_BCD) ? '0 : (ones == 4'd9) ? {tens + 1'b1, 4'd0} : {tens, ones + 4'd1};
        dn = (value == '0) ? MAX_BCD : (ones == 4'd0) ? {tens - 1'b1, 4'd9} : {tens, ones - 4'd1};
    end
    always_ff @(posedge clk or posedge rst)
        if (rst)                value <= '0;
        else if (clr)           value <= '0;
        else if (inc && !dec)   value <= up;
        else if (dec && !inc)   value <= dn;
endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 24-hour BCD timekeeping with button-driven hour/minute setting
// Ports: clk, rst (async, active-high); mode_p/inc_p/dec_p debounced button pulses;
// hr_bcd/min_bcd/sec_bcd BCD time; set_hr/set_min field-select flags;
// blink = first half of each prescaler second; sec_tick pulses when seconds advance.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int SYSCLK_FREQ = 24000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode_p,
    input  logic            inc_p,
    input  logic            dec_p,
    output logic [HR_W-1:0] hr_bcd,
    output logic [MS_W-1:0] min_bcd,
    output logic [MS_W-1:0] sec_bcd,
    output logic            set_hr,
    output logic            set_min,
    output logic            blink,
    output logic            sec_tick
);
    localparam int PW = $clog2(SYSCLK_FREQ);
    state_t        state, state_n;
    logic [PW-1:0] presc;
    logic          run, tick, sec_carry, min_carry;
    assign run   = state == RUN;
    // mode_p outranks the tick, so a tick coinciding with it is dropped
    assign tick  = run && !mode_p && presc == PW'(SYSCLK_FREQ - 1);
    assign blink = presc < PW'(SYSCLK_FREQ / 2);
    always_comb begin
        state_n = state;
        if (mode_p) state_n = (state == RUN) ? SET_HR : (state == SET_HR) ? SET_MIN : RUN;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= RUN;
            presc    <= '0;
            set_hr   <= 1'b0;
            set_min  <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            state    <= state_n;
            // restart the second on leaving SET_MIN so the first tick is a full second away
            presc    <= ((mode_p && state == SET_MIN) || presc == PW'(SYSCLK_FREQ - 1)) ? '0 : presc + 1'b1;
            set_hr   <= state_n == SET_HR;
            set_min  <= state_n == SET_MIN;
            sec_tick <= tick;
        end
    bcd2_wrap_ctr #(.MAX(MS_MAX), .W(MS_W)) u_sec (
        .clk(clk), .rst(rst),
        .inc(tick), .dec(1'b0), .clr(mode_p && run),
        .value(sec_bcd), .carry(sec_carry)
    );
    bcd2_wrap_ctr #(.MAX(MS_MAX), .W(MS_W)) u_min (
        .clk(clk), .rst(rst),
        .inc(sec_carry || (state == SET_MIN && !mode_p && inc_p)),
        .dec(state == SET_MIN && !mode_p && dec_p),
        .clr(1'b0),
        .value(min_bcd), .carry(min_carry)
    );
    // minute wrap while setting must not reach the hours, so only RUN carries propagate
    bcd2_wrap_ctr #(.MAX(HR_MAX), .W(HR_W)) u_hr (
        .clk(clk), .rst(rst),
        .inc((run && min_carry) || (state == SET_HR && !mode_p && inc_p)),
        .dec(state == SET_HR && !mode_p && dec_p),
        .clr(1'b0),
        .value(hr_bcd), .carry()
    );
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed stimulus against an arithmetic time model plus literal expectations
module tb_clock_time_ctrl;
    localparam int F = 8;
    logic       clk = 1'b0, rst = 1'b1, mode_p = 1'b0, inc_p = 1'b0, dec_p = 1'b0;
    logic [5:0] hr_bcd;
    logic [6:0] min_bcd, sec_bcd;
    logic       set_hr, set_min, blink, sec_tick;
    int         checks = 0, errors = 0;
    int         mh = 0, mm = 0, ms = 0, mp = 0, mst = 0, secs = 0;
    bit         mtick = 0, mt = 0;
    int         n, tcnt, trans;
    logic       prev;

    clock_time_ctrl #(.SYSCLK_FREQ(F)) dut (
        .clk(clk), .rst(rst), .mode_p(mode_p), .inc_p(inc_p), .dec_p(dec_p),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .set_hr(set_hr), .set_min(set_min), .blink(blink), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    function automatic int bcd(int v);
        return (v / 10) * 16 + v % 10;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: state 0=RUN 1=SET_HR 2=SET_MIN, time kept as plain integers
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mh = 0; mm = 0; ms = 0; mp = 0; mst = 0; mtick = 0;
        end else begin
            mt    = (mst == 0 && mp == F - 1 && !mode_p);
            mp    = (mode_p && mst == 2) ? 0 : (mp + 1) % F;
            mtick = mt;
            if (mode_p) begin
                if (mst == 0) ms = 0;
                mst = (mst + 1) % 3;
            end else if (mst == 1 && inc_p != dec_p) mh = inc_p ? (mh + 1) % 24 : (mh + 23) % 24;
            else if (mst == 2 && inc_p != dec_p) mm = inc_p ? (mm + 1) % 60 : (mm + 59) % 60;
            else if (mt) begin
                secs = ((mh * 60 + mm) * 60 + ms + 1) % 86400;
                mh = secs / 3600; mm = (secs / 60) % 60; ms = secs % 60;
            end
        end
    end

    always @(negedge clk) begin
        check("hr_bcd", 32'(hr_bcd), bcd(mh));
        check("min_bcd", 32'(min_bcd), bcd(mm));
        check("sec_bcd", 32'(sec_bcd), bcd(ms));
        check("set_hr", 32'(set_hr), 32'(mst == 1));
        check("set_min", 32'(set_min), 32'(mst == 2));
        check("sec_tick", 32'(sec_tick), 32'(mtick));
        check("blink", 32'(blink), 32'(mp < F / 2));
    end

    task automatic step(bit m, bit i, bit d);
        @(negedge clk);
        mode_p = m; inc_p = i; dec_p = d;
        @(posedge clk);
        #1;
        mode_p = 0; inc_p = 0; dec_p = 0;
    endtask

    task automatic idle(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!sec_tick && cnt < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle(2);
        rst = 1'b0;
        check("reset_hr", 32'(hr_bcd), 0);
        check("reset_blink", 32'(blink), 1);
        // scenario 1: reach 12:34:56, then reset asynchronously mid-cycle
        step(1, 0, 0);
        repeat (12) step(0, 1, 0);
        step(1, 0, 0);
        repeat (34) step(0, 1, 0);
        step(1, 0, 0);
        idle(449);
        check("pre_reset_hr", 32'(hr_bcd), 32'h12);
        check("pre_reset_min", 32'(min_bcd), 32'h34);
        check("pre_reset_sec", 32'(sec_bcd), 32'h56);
        idle(3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_time", {hr_bcd, min_bcd, sec_bcd}, 0);
        check("async_rst_flags", {set_hr, set_min, sec_tick}, 0);
        check("async_rst_blink", 32'(blink), 1);
        @(negedge clk);
        rst = 1'b0;
        // scenario 2: set 23:59, run 60 ticks
        step(1, 0, 0);
        step(0, 0, 1);
        check("set_hr_23", 32'(hr_bcd), 32'h23);
        step(1, 0, 0);
        step(0, 0, 1);
        check("set_min_59", 32'(min_bcd), 32'h59);
        step(1, 0, 0);
        wait_tick(n);
        check("first_tick_T9", n, 9);
        for (int k = 2; k <= 60; k++) begin
            wait_tick(n);
            check("tick_spacing", n, 8);
        end
        check("rollover_time", {hr_bcd, min_bcd, sec_bcd}, 0);
        // scenario 3: hour wrap both ways, seconds cleared on entry
        repeat (3) wait_tick(n);
        check("sec_before_set", 32'(sec_bcd), 32'h03);
        step(1, 0, 0);
        check("entry_sec_clr", 32'(sec_bcd), 0);
        step(0, 0, 1);
        check("hr_dec_wrap", 32'(hr_bcd), 32'h23);
        step(0, 1, 0);
        check("hr_inc_wrap", 32'(hr_bcd), 0);
        check("hr_wrap_min", 32'(min_bcd), 0);
        // scenario 4: minute wrap does not carry into hours
        repeat (5) step(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 1, 0);
        check("min_inc_wrap", 32'(min_bcd), 0);
        check("min_wrap_hr", 32'(hr_bcd), 32'h05);
        // scenario 5: simultaneous events
        repeat (7) step(0, 1, 0);
        step(0, 1, 1);
        check("inc_dec_hold", 32'(min_bcd), 32'h07);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        check("mode_inc_state", {set_hr, set_min}, 32'b01);
        check("mode_inc_hr", 32'(hr_bcd), 32'h05);
        step(1, 0, 0);
        repeat (2) wait_tick(n);
        check("sec_before_mode", 32'(sec_bcd), 32'h02);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mp != F - 1 && n < 20);
        check("found_tick_cycle", 32'(n < 20), 1);
        mode_p = 1'b1;
        @(posedge clk);
        #1 mode_p = 1'b0;
        @(negedge clk);
        check("mode_tick_state", 32'(set_hr), 1);
        check("mode_tick_sec", 32'(sec_bcd), 0);
        check("mode_tick_pulse", 32'(sec_tick), 0);
        // scenario 6: 40 cycles in SET_HR, then exit timing
        tcnt = 0; trans = 0; prev = blink;
        repeat (40) begin
            @(negedge clk);
            if (sec_tick) tcnt++;
            if (blink != prev) trans++;
            prev = blink;
        end
        check("set_no_ticks", tcnt, 0);
        check("blink_toggles", trans, 10);
        step(1, 0, 0);
        step(1, 0, 0);
        wait_tick(n);
        check("exit_tick_T9", n, 9);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
